// File: rtl/syn_fgyrus_pkg.sv
// rtl/syn_fgyrus_pkg.sv - shared types, constants and helpers for the fgyrus spectrum blocks
//
// Contents:
//   fsm_state_t  : frame sequencer states (IDLE, WAIT, READ, DRAIN, DONE)
//   MAG_BETA_SH1 : first shift of the 3/8 beta term (mn >> 2)
//   MAG_BETA_SH2 : second shift of the 3/8 beta term (mn >> 3)
//   abs_sat()    : absolute value of a w-bit signed word, saturating the most
//                  negative input so the result always fits in w-1 magnitude bits

package syn_fgyrus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } fsm_state_t;

    // 3/8 = 1/4 + 1/8
    localparam int MAG_BETA_SH1 = 2;
    localparam int MAG_BETA_SH2 = 3;

    // x is a w-bit signed value sign-extended to 64 bits (w <= 64).
    // -2**(w-1) has no positive counterpart in w bits, so it maps to 2**(w-1)-1.
    function automatic logic [63:0] abs_sat(input logic signed [63:0] x,
                                            input int unsigned        w);
        logic signed [63:0] min_neg;
        min_neg = -(64'sd1 <<< (w - 1));
        if (x == min_neg) begin
            return (64'd1 << (w - 1)) - 64'd1;
        end else if (x < 0) begin
            return -x;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/syn_fgyrus_fft_mag_calc_approx.sv
// rtl/syn_fgyrus_fft_mag_calc_approx.sv - 3-stage alpha-max-beta-min magnitude pipeline
//
// Module syn_mag_approx: |X| ~ max(|re|,|im|) + 3/8*min(|re|,|im|), one sample per cycle.
// A valid bit and an address travel alongside the data so the output can be
// written straight into a RAM.
//
// Ports:
//   clk        in   1       clock
//   resetn     in   1       synchronous reset, active low (clears valids and outputs)
//   in_valid   in   1       sample valid
//   in_addr    in   ADDR_W  sideband address for the sample
//   in_re      in   DATA_W  real part, signed
//   in_im      in   DATA_W  imaginary part, signed
//   out_valid  out  1       result valid, 3 cycles after in_valid
//   out_addr   out  ADDR_W  address that entered with the sample
//   out_data   out  DATA_W  unsigned magnitude

module syn_mag_approx
    import syn_fgyrus_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data
);

    logic              v_s1, v_s2;
    logic [ADDR_W-1:0] addr_s1, addr_s2;
    logic [DATA_W-1:0] a_s1, b_s1;
    logic [DATA_W-1:0] mx_s2, mn_s2;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            v_s1      <= 1'b0;
            v_s2      <= 1'b0;
            out_valid <= 1'b0;
            addr_s1   <= '0;
            addr_s2   <= '0;
            out_addr  <= '0;
            a_s1      <= '0;
            b_s1      <= '0;
            mx_s2     <= '0;
            mn_s2     <= '0;
            out_data  <= '0;
        end else begin
            // S1: absolute values
            v_s1    <= in_valid;
            addr_s1 <= in_addr;
            a_s1    <= DATA_W'(abs_sat(64'(in_re), DATA_W));
            b_s1    <= DATA_W'(abs_sat(64'(in_im), DATA_W));

            // S2: sort
            v_s2    <= v_s1;
            addr_s2 <= addr_s1;
            if (a_s1 >= b_s1) begin
                mx_s2 <= a_s1;
                mn_s2 <= b_s1;
            end else begin
                mx_s2 <= b_s1;
                mn_s2 <= a_s1;
            end

            // S3: inputs are at most 2**(DATA_W-1)-1, so the sum stays below
            // 1.375*2**(DATA_W-1) and cannot wrap in DATA_W bits.
            out_valid <= v_s2;
            out_addr  <= addr_s2;
            out_data  <= mx_s2 + (mn_s2 >> MAG_BETA_SH1) + (mn_s2 >> MAG_BETA_SH2);
        end
    end

endmodule

// File: rtl/syn_fgyrus_fft_mag_calc.sv
// rtl/syn_fgyrus_fft_mag_calc.sv - FFT RAM to magnitude RAM frame converter
//
// On each accepted fft_done pulse, reads bins 0..NUM_BINS-1 from the FFT RAM,
// computes an alpha-max-beta-min magnitude per bin and writes it to the
// magnitude RAM at the same index, then pulses mag_done.
//
// Ports:
//   sys_clk_100          in   1       system clock
//   sys_rst_n            in   1       synchronous reset, active low
//   fft_done             in   1       pulse: FFT RAM holds a complete frame
//   mag_ram_lock         in   1       consumer is reading the magnitude RAM
//   fft_ram_rd_en        out  1       FFT RAM read strobe
//   fft_ram_rd_addr      out  ADDR_W  FFT RAM read address
//   fft_ram_rd_real_data in   DATA_W  real word, RD_LAT cycles after rd_en
//   fft_ram_rd_im_data   in   DATA_W  imaginary word, same timing
//   mag_ram_wr_en        out  1       magnitude RAM write strobe
//   mag_ram_wr_addr      out  ADDR_W  magnitude RAM write address (bin index)
//   mag_ram_wr_data      out  DATA_W  unsigned magnitude
//   mag_done             out  1       pulse after the last bin is written
//   busy                 out  1       frame accepted and not yet finished
//   fft_ovr              out  1       pulse: fft_done arrived while not idle

module syn_fgyrus_fft_mag_calc
    import syn_fgyrus_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int NUM_BINS = 64,
    parameter int RD_LAT   = 1
) (
    input  logic              sys_clk_100,
    input  logic              sys_rst_n,
    input  logic              fft_done,
    input  logic              mag_ram_lock,
    output logic              fft_ram_rd_en,
    output logic [ADDR_W-1:0] fft_ram_rd_addr,
    input  logic [DATA_W-1:0] fft_ram_rd_real_data,
    input  logic [DATA_W-1:0] fft_ram_rd_im_data,
    output logic              mag_ram_wr_en,
    output logic [ADDR_W-1:0] mag_ram_wr_addr,
    output logic [DATA_W-1:0] mag_ram_wr_data,
    output logic              mag_done,
    output logic              busy,
    output logic              fft_ovr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);

    fsm_state_t        state;
    logic [RD_LAT-1:0] vld_sr;
    logic [ADDR_W-1:0] addr_sr [RD_LAT];

    // Frame sequencer. mag_done is registered from the DONE state, so it
    // appears in the first IDLE cycle; busy is held through that cycle and a
    // new fft_done seen there is accepted immediately.
    always_ff @(posedge sys_clk_100) begin
        if (!sys_rst_n) begin
            state           <= ST_IDLE;
            fft_ram_rd_en   <= 1'b0;
            fft_ram_rd_addr <= '0;
            mag_done        <= 1'b0;
            busy            <= 1'b0;
            fft_ovr         <= 1'b0;
        end else begin
            mag_done <= 1'b0;
            fft_ovr  <= fft_done && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    busy <= fft_done;
                    if (fft_done) begin
                        if (mag_ram_lock) begin
                            state <= ST_WAIT;
                        end else begin
                            state           <= ST_READ;
                            fft_ram_rd_en   <= 1'b1;
                            fft_ram_rd_addr <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!mag_ram_lock) begin
                        state           <= ST_READ;
                        fft_ram_rd_en   <= 1'b1;
                        fft_ram_rd_addr <= '0;
                    end
                end
                ST_READ: begin
                    if (fft_ram_rd_addr == LAST_ADDR) begin
                        state           <= ST_DRAIN;
                        fft_ram_rd_en   <= 1'b0;
                        fft_ram_rd_addr <= '0;
                    end else begin
                        fft_ram_rd_addr <= fft_ram_rd_addr + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (mag_ram_wr_en && (mag_ram_wr_addr == LAST_ADDR)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    mag_done <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Delay rd_en/addr by the RAM read latency so they line up with the data.
    always_ff @(posedge sys_clk_100) begin
        if (!sys_rst_n) begin
            vld_sr <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_sr[i] <= '0;
            end
        end else begin
            vld_sr[0]  <= fft_ram_rd_en;
            addr_sr[0] <= fft_ram_rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                addr_sr[i] <= addr_sr[i-1];
            end
        end
    end

    syn_mag_approx #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mag_approx (
        .clk       (sys_clk_100),
        .resetn    (sys_rst_n),
        .in_valid  (vld_sr[RD_LAT-1]),
        .in_addr   (addr_sr[RD_LAT-1]),
        .in_re     (signed'(fft_ram_rd_real_data)),
        .in_im     (signed'(fft_ram_rd_im_data)),
        .out_valid (mag_ram_wr_en),
        .out_addr  (mag_ram_wr_addr),
        .out_data  (mag_ram_wr_data)
    );

endmodule

// File: tb/tb_syn_fgyrus_fft_mag_calc.sv
// tb/tb_syn_fgyrus_fft_mag_calc.sv - self-checking bench for syn_fgyrus_fft_mag_calc
`timescale 1ns/1ps

module tb_syn_fgyrus_fft_mag_calc;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 32;
    localparam int NUM_BINS  = 64;
    localparam int RD_LAT    = 2;
    localparam int FRAME_LAT = NUM_BINS + RD_LAT + 5;
    localparam int NVEC      = 12;

    logic              clk;
    logic              rst_n;
    logic              fft_done;
    logic              lock;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_re, rd_im;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              mag_done;
    logic              busy;
    logic              fft_ovr;

    syn_fgyrus_fft_mag_calc #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_BINS (NUM_BINS),
        .RD_LAT   (RD_LAT)
    ) dut (
        .sys_clk_100          (clk),
        .sys_rst_n            (rst_n),
        .fft_done             (fft_done),
        .mag_ram_lock         (lock),
        .fft_ram_rd_en        (rd_en),
        .fft_ram_rd_addr      (rd_addr),
        .fft_ram_rd_real_data (rd_re),
        .fft_ram_rd_im_data   (rd_im),
        .mag_ram_wr_en        (wr_en),
        .mag_ram_wr_addr      (wr_addr),
        .mag_ram_wr_data      (wr_data),
        .mag_done             (mag_done),
        .busy                 (busy),
        .fft_ovr              (fft_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FFT RAM model with two-cycle read latency
    logic [DATA_W-1:0] re_mem [128];
    logic [DATA_W-1:0] im_mem [128];
    logic [DATA_W-1:0] re_d1, im_d1, re_d2, im_d2;
    always @(posedge clk) begin
        if (rd_en) begin
            re_d1 <= re_mem[rd_addr];
            im_d1 <= im_mem[rd_addr];
        end
        re_d2 <= re_d1;
        im_d2 <= im_d1;
    end
    assign rd_re = re_d2;
    assign rd_im = im_d2;

    // Output monitor
    logic [DATA_W-1:0] exp_mem [128];
    logic [DATA_W-1:0] cap_data [128];
    int wr_cnt, done_cnt, ovr_cnt, seq_err, data_err;
    int done_cyc, first_rd_cyc, last_wr_cyc;
    logic busy_at_done;

    always @(negedge clk) begin
        if (wr_en) begin
            cap_data[wr_addr] = wr_data;
            if (int'(wr_addr) != (wr_cnt % NUM_BINS)) seq_err++;
            if (wr_addr != 0 && cyc != last_wr_cyc + 1) seq_err++;
            if (wr_data !== exp_mem[wr_addr]) data_err++;
            last_wr_cyc = cyc;
            wr_cnt++;
        end
        if (mag_done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        if (fft_ovr) ovr_cnt++;
        if (rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wr_cnt = 0; done_cnt = 0; ovr_cnt = 0; seq_err = 0; data_err = 0;
        done_cyc = -1; first_rd_cyc = -1; last_wr_cyc = -10; busy_at_done = 1'b0;
    endtask

    task automatic pulse_fft(output int t0);
        @(posedge clk); #1;
        fft_done = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        fft_done = 1'b0;
    endtask

    task automatic wait_done(input int n_done, input int bound);
        int k;
        k = 0;
        while (done_cnt < n_done && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("mag_done_count", 64'(done_cnt), 64'(n_done));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_flags"}, 64'({rd_en, wr_en, mag_done, busy, fft_ovr}), 64'd0);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    endtask

    function automatic logic [31:0] ref_mag(input logic [31:0] re, input logic [31:0] im);
        longint a, b, mx, mn;
        a = longint'(signed'(re));
        b = longint'(signed'(im));
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        if (a > 64'sh7FFF_FFFF) a = 64'sh7FFF_FFFF;
        if (b > 64'sh7FFF_FFFF) b = 64'sh7FFF_FFFF;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return 32'(mx + mn / 4 + mn / 8);
    endfunction

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [NVEC];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, trel, err, mism;

        rst_n    = 1'b0;
        fft_done = 1'b0;
        lock     = 1'b0;
        for (int i = 0; i < 128; i++) begin
            re_mem[i] = '0; im_mem[i] = '0; exp_mem[i] = '0; cap_data[i] = '0;
        end
        clear_mon();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven frame: hand-computed magnitudes in bins 0..11, 3/4 elsewhere
        vecs[0]  = '{32'd3,          32'd4,          32'd4};
        vecs[1]  = '{32'd0,          32'd0,          32'd0};
        vecs[2]  = '{32'hFFFF_FFF8,  32'd16,         32'd19};
        vecs[3]  = '{32'd100,        32'hFFFF_FFD8,  32'd115};
        vecs[4]  = '{32'h8000_0000,  32'd0,          32'h7FFF_FFFF};
        vecs[5]  = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'hAFFF_FFFD};
        vecs[6]  = '{32'h8000_0000,  32'h8000_0000,  32'hAFFF_FFFD};
        vecs[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1};
        vecs[8]  = '{32'd64,         32'hFFFF_FFC0,  32'd88};
        vecs[9]  = '{32'hFFFF_FC18,  32'd3,          32'd1000};
        vecs[10] = '{32'd0,          32'h8000_0000,  32'h7FFF_FFFF};
        vecs[11] = '{32'h7FFF_FFFF,  32'h8000_0000,  32'hAFFF_FFFD};

        for (int i = 0; i < NUM_BINS; i++) begin
            if (i < NVEC) begin
                re_mem[i] = vecs[i].re; im_mem[i] = vecs[i].im; exp_mem[i] = vecs[i].exp;
            end else begin
                re_mem[i] = 32'd3; im_mem[i] = 32'd4; exp_mem[i] = 32'd4;
            end
        end
        clear_mon();
        pulse_fft(t0);
        wait_done(1, 300);
        check("f1_wr_count", 64'(wr_cnt), 64'(NUM_BINS));
        check("f1_addr_seq_err", 64'(seq_err), 64'd0);
        check("f1_data_err", 64'(data_err), 64'd0);
        check("f1_first_rd_cycle", 64'(first_rd_cyc), 64'(t0 + 1));
        check("f1_mag_done_cycle", 64'(done_cyc), 64'(t0 + FRAME_LAT));
        check("f1_busy_at_done", 64'(busy_at_done), 64'd1);
        for (int i = 0; i < NVEC; i++) begin
            check($sformatf("vec%0d_mag", i), 64'(cap_data[i]), 64'(vecs[i].exp));
        end
        check("f1_last_bin_mag", 64'(cap_data[NUM_BINS-1]), 64'd4);
        repeat (3) @(negedge clk);
        check("f1_busy_after", 64'(busy), 64'd0);

        // Lock held 20 cycles: no reads until release; lock rising mid-frame ignored
        clear_mon();
        lock = 1'b1;
        pulse_fft(t0);
        err = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_en) err++;
            if (!busy) err++;
        end
        check("lock_hold_errors", 64'(err), 64'd0);
        @(posedge clk); #1;
        lock = 1'b0;
        trel = cyc;
        repeat (10) @(posedge clk);
        #1 lock = 1'b1;
        wait_done(1, 300);
        lock = 1'b0;
        check("lock_first_rd_cycle", 64'(first_rd_cyc), 64'(trel + 1));
        check("lock_wr_count", 64'(wr_cnt), 64'(NUM_BINS));
        check("lock_addr_seq_err", 64'(seq_err), 64'd0);
        check("lock_mag_done_cycle", 64'(done_cyc), 64'(trel + FRAME_LAT));

        // Second fft_done around bin 30: one fft_ovr, frame unaffected
        repeat (5) @(posedge clk);
        clear_mon();
        pulse_fft(t0);
        repeat (29) @(posedge clk);
        pulse_fft(t1);
        wait_done(1, 300);
        repeat (100) @(negedge clk);
        check("ovr_pulse_count", 64'(ovr_cnt), 64'd1);
        check("ovr_wr_count", 64'(wr_cnt), 64'(NUM_BINS));
        check("ovr_done_count", 64'(done_cnt), 64'd1);
        check("ovr_addr_seq_err", 64'(seq_err), 64'd0);
        check("ovr_mag_done_cycle", 64'(done_cyc), 64'(t0 + FRAME_LAT));

        // Reset at bin 40 aborts the frame
        clear_mon();
        pulse_fft(t0);
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        clear_mon();
        pulse_fft(t0);
        wait_done(1, 300);
        check("postrst_wr_count", 64'(wr_cnt), 64'(NUM_BINS));
        check("postrst_addr_seq_err", 64'(seq_err), 64'd0);
        check("postrst_data_err", 64'(data_err), 64'd0);

        // Random data, back-to-back frames (second fft_done in the mag_done cycle)
        for (int i = 0; i < NUM_BINS; i++) begin
            re_mem[i]  = $urandom;
            im_mem[i]  = $urandom;
            exp_mem[i] = ref_mag(re_mem[i], im_mem[i]);
        end
        re_mem[5] = 32'h8000_0000;
        exp_mem[5] = ref_mag(re_mem[5], im_mem[5]);
        repeat (5) @(posedge clk);
        clear_mon();
        pulse_fft(t0);
        t1 = t0 + FRAME_LAT;
        while (cyc < t1) begin
            @(posedge clk); #1;
        end
        fft_done = 1'b1;
        @(posedge clk); #1;
        fft_done = 1'b0;
        wait_done(2, 400);
        check("b2b_first_done_ok", 64'(ovr_cnt), 64'd0);
        check("b2b_wr_count", 64'(wr_cnt), 64'(2 * NUM_BINS));
        check("b2b_addr_seq_err", 64'(seq_err), 64'd0);
        check("b2b_data_err", 64'(data_err), 64'd0);
        check("b2b_second_done_cycle", 64'(done_cyc), 64'(t1 + FRAME_LAT));
        mism = 0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (cap_data[i] !== exp_mem[i]) mism++;
        end
        check("b2b_ram_contents", 64'(mism), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
